// File: rtl/home_inventory_pkg.sv
// Shared types and helpers for the home-inventory sample/event path.
package home_inventory_pkg;

    localparam int unsigned NUM_CH   = 8;
    localparam int unsigned CH_IDX_W = 3;
    localparam int unsigned SAMPLE_W = 32;
    localparam int unsigned TS_W     = 32;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } seq_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/home_inventory_ts_counter.sv
// Free-running prescaled timestamp; wraps modulo 2^TS_W.
module home_inventory_ts_counter
    import home_inventory_pkg::*;
#(
    parameter int unsigned      TS_PRESCALE    = 1,
    parameter logic [TS_W-1:0]  TS_RESET_VALUE = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [TS_W-1:0] ts
);

    logic [31:0] presc;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            ts    <= TS_RESET_VALUE;
        end else if (presc == 32'(TS_PRESCALE - 1)) begin
            presc <= '0;
            ts    <= ts + 32'd1;
        end else begin
            presc <= presc + 32'd1;
        end
    end

endmodule

// File: rtl/home_inventory_sample_sequencer.sv
// Assembles in-order ch0..ch7 ADC words into a timestamped snapshot frame.
module home_inventory_sample_sequencer
    import home_inventory_pkg::*;
#(
    parameter int unsigned      TS_PRESCALE    = 1,
    parameter int unsigned      TIMEOUT_CYCLES = 1024,
    parameter logic [TS_W-1:0]  TS_RESET_VALUE = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                adc_valid,
    output logic                adc_ready,
    input  logic [2:0]          adc_ch,
    input  logic [31:0]         adc_data,
    output logic                sample_valid,
    output logic [31:0]         ts_now,
    output logic [31:0]         sample_ch0,
    output logic [31:0]         sample_ch1,
    output logic [31:0]         sample_ch2,
    output logic [31:0]         sample_ch3,
    output logic [31:0]         sample_ch4,
    output logic [31:0]         sample_ch5,
    output logic [31:0]         sample_ch6,
    output logic [31:0]         sample_ch7,
    output logic [31:0]         ts_counter,
    output logic [31:0]         frame_count,
    output logic [31:0]         drop_count,
    output logic                busy
);

    seq_state_t            state, state_n;
    logic [CH_IDX_W-1:0]   exp_ch, exp_ch_n;
    logic [31:0]           to_cnt, to_cnt_n;
    logic                  accept, start, store, emit, drop;
    logic [SAMPLE_W-1:0]   shadow  [NUM_CH-1];
    logic [SAMPLE_W-1:0]   samples [NUM_CH];
    logic [TS_W-1:0]       ts_cap;

    home_inventory_ts_counter #(
        .TS_PRESCALE    (TS_PRESCALE),
        .TS_RESET_VALUE (TS_RESET_VALUE)
    ) u_ts (
        .clk (clk),
        .rst (rst),
        .ts  (ts_counter)
    );

    assign adc_ready = enable;
    assign accept    = adc_valid && enable;
    assign busy      = (state == ST_COLLECT);

    always_comb begin
        state_n  = state;
        exp_ch_n = exp_ch;
        to_cnt_n = to_cnt;
        start    = 1'b0;
        store    = 1'b0;
        emit     = 1'b0;
        drop     = 1'b0;
        case (state)
            ST_IDLE: begin
                to_cnt_n = '0;
                if (accept && adc_ch == 3'd0) begin
                    start    = 1'b1;
                    exp_ch_n = 3'd1;
                    state_n  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // Disable abandons silently and takes precedence over timeout.
                if (!enable) begin
                    state_n  = ST_IDLE;
                    to_cnt_n = '0;
                end else if (accept) begin
                    to_cnt_n = '0;
                    if (adc_ch == exp_ch) begin
                        if (exp_ch == 3'd7) begin
                            emit    = 1'b1;
                            state_n = ST_IDLE;
                        end else begin
                            store    = 1'b1;
                            exp_ch_n = exp_ch + 3'd1;
                        end
                    end else begin
                        drop = 1'b1;
                        if (adc_ch == 3'd0) begin
                            start    = 1'b1;
                            exp_ch_n = 3'd1;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end
                end else if ((TIMEOUT_CYCLES != 0) &&
                             (to_cnt == 32'(TIMEOUT_CYCLES - 1))) begin
                    drop     = 1'b1;
                    state_n  = ST_IDLE;
                    to_cnt_n = '0;
                end else begin
                    to_cnt_n = to_cnt + 32'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            exp_ch       <= '0;
            to_cnt       <= '0;
            ts_cap       <= '0;
            sample_valid <= 1'b0;
            ts_now       <= '0;
            frame_count  <= '0;
            drop_count   <= '0;
            for (int unsigned i = 0; i < NUM_CH - 1; i++) shadow[i] <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) samples[i] <= '0;
        end else begin
            state        <= state_n;
            exp_ch       <= exp_ch_n;
            to_cnt       <= to_cnt_n;
            sample_valid <= emit;
            if (start) begin
                shadow[0] <= adc_data;
                ts_cap    <= ts_counter;
            end
            for (int unsigned i = 1; i < NUM_CH - 1; i++) begin
                if (store && exp_ch == CH_IDX_W'(i)) shadow[i] <= adc_data;
            end
            // ch7 bypasses the shadow so the frame is published on its handshake edge.
            if (emit) begin
                for (int unsigned i = 0; i < NUM_CH - 1; i++) samples[i] <= shadow[i];
                samples[NUM_CH-1] <= adc_data;
                ts_now            <= ts_cap;
                frame_count       <= sat_inc(frame_count);
            end
            if (drop) drop_count <= sat_inc(drop_count);
        end
    end

    assign sample_ch0 = samples[0];
    assign sample_ch1 = samples[1];
    assign sample_ch2 = samples[2];
    assign sample_ch3 = samples[3];
    assign sample_ch4 = samples[4];
    assign sample_ch5 = samples[5];
    assign sample_ch6 = samples[6];
    assign sample_ch7 = samples[7];

endmodule

// File: tb/tb_home_inventory_sample_sequencer.sv
// Directed bench for the sample sequencer: prescale 4, reset ts FFFF_FFFE, timeout 16.
module tb_home_inventory_sample_sequencer;

    logic        clk = 1'b0;
    logic        rst, enable, adc_valid, adc_ready;
    logic [2:0]  adc_ch;
    logic [31:0] adc_data;
    logic        sample_valid, busy;
    logic [31:0] ts_now, ts_counter, frame_count, drop_count;
    logic [31:0] sample_ch0, sample_ch1, sample_ch2, sample_ch3;
    logic [31:0] sample_ch4, sample_ch5, sample_ch6, sample_ch7;

    int tests  = 0;
    int failed = 0;
    int ticks  = 0;
    logic [31:0] cap_ts;
    logic [31:0] prev_ch0;

    always #5 clk = ~clk;

    // Clock edges since the last reset edge; reference timestamp = FFFF_FFFE + ticks/4.
    always @(posedge clk) begin
        if (rst) ticks <= 0;
        else     ticks <= ticks + 1;
    end

    home_inventory_sample_sequencer #(
        .TS_PRESCALE    (4),
        .TIMEOUT_CYCLES (16),
        .TS_RESET_VALUE (32'hFFFF_FFFE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .adc_valid    (adc_valid),
        .adc_ready    (adc_ready),
        .adc_ch       (adc_ch),
        .adc_data     (adc_data),
        .sample_valid (sample_valid),
        .ts_now       (ts_now),
        .sample_ch0   (sample_ch0),
        .sample_ch1   (sample_ch1),
        .sample_ch2   (sample_ch2),
        .sample_ch3   (sample_ch3),
        .sample_ch4   (sample_ch4),
        .sample_ch5   (sample_ch5),
        .sample_ch6   (sample_ch6),
        .sample_ch7   (sample_ch7),
        .ts_counter   (ts_counter),
        .frame_count  (frame_count),
        .drop_count   (drop_count),
        .busy         (busy)
    );

    function automatic logic [31:0] model_ts();
        return 32'hFFFF_FFFE + 32'(ticks / 4);
    endfunction

    function automatic logic [31:0] sample_at(input int k);
        logic [31:0] r;
        case (k)
            0: r = sample_ch0;  1: r = sample_ch1;
            2: r = sample_ch2;  3: r = sample_ch3;
            4: r = sample_ch4;  5: r = sample_ch5;
            6: r = sample_ch6;  default: r = sample_ch7;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] ch, input logic [31:0] d);
        if (ch == 3'd0) cap_ts = model_ts();
        adc_valid = 1'b1;
        adc_ch    = ch;
        adc_data  = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        adc_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; adc_valid = 1'b0; adc_ch = '0; adc_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, adc_ready}, 32'd0);
        check("rst_ts_now", ts_now, 32'd0);
        check("rst_frames", frame_count, 32'd0);
        check("rst_drops", drop_count, 32'd0);
        check("rst_ch0", sample_ch0, 32'd0);
        check("rst_ts_counter", ts_counter, 32'hFFFF_FFFE);

        // Prescale 4 and wrap: FE x4, FF x4, then the 0 window.
        for (int i = 0; i < 10; i++) begin
            check("ts_wrap", ts_counter, (i < 4) ? 32'hFFFF_FFFE : (i < 8) ? 32'hFFFF_FFFF : 32'h0);
            @(negedge clk);
        end

        // Normal frame, ch0 accepted inside the ts==0 window.
        enable = 1'b1;
        #1 check("ready_en", {31'd0, adc_ready}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            check("pre_strobe", {31'd0, sample_valid}, 32'd0);
            send(3'(k), 32'h100 + 32'(k));
        end
        check("norm_valid", {31'd0, sample_valid}, 32'd1);
        for (int k = 0; k < 8; k++) check("norm_sample", sample_at(k), 32'h100 + 32'(k));
        check("norm_ts_now", ts_now, 32'h0);
        check("norm_ts_model", cap_ts, 32'h0);
        check("norm_frames", frame_count, 32'd1);
        check("norm_drops", drop_count, 32'd0);
        check("norm_busy", {31'd0, busy}, 32'd0);
        idle(1);
        check("norm_pulse", {31'd0, sample_valid}, 32'd0);

        // Order error: 0,1,3 aborts.
        send(3'd0, 32'h200); send(3'd1, 32'h201); send(3'd3, 32'h203);
        check("ord1_drops", drop_count, 32'd1);
        check("ord1_busy", {31'd0, busy}, 32'd0);
        idle(1);
        check("ord1_nostrobe", {31'd0, sample_valid}, 32'd0);

        // Repeated ch0 restarts the frame from the second ch0.
        send(3'd0, 32'hAA); send(3'd1, 32'hAB);
        for (int k = 0; k < 8; k++) send(3'(k), 32'h300 + 32'(k));
        check("ord2_valid", {31'd0, sample_valid}, 32'd1);
        check("ord2_drops", drop_count, 32'd2);
        check("ord2_ch0", sample_ch0, 32'h300);
        check("ord2_ch7", sample_ch7, 32'h307);
        check("ord2_ts_now", ts_now, cap_ts);
        check("ord2_frames", frame_count, 32'd2);

        // Stray ch5 in IDLE is ignored.
        send(3'd5, 32'h555);
        idle(1);
        check("stray_drops", drop_count, 32'd2);
        check("stray_busy", {31'd0, busy}, 32'd0);

        // Timeout 16 cycles after the ch3 handshake.
        for (int k = 0; k < 4; k++) send(3'(k), 32'h400 + 32'(k));
        idle(15);
        check("to_busy_15", {31'd0, busy}, 32'd1);
        check("to_drops_15", drop_count, 32'd2);
        idle(1);
        check("to_busy_16", {31'd0, busy}, 32'd0);
        check("to_drops_16", drop_count, 32'd3);
        for (int k = 0; k < 8; k++) send(3'(k), 32'h480 + 32'(k));
        check("to_frames", frame_count, 32'd3);
        check("to_ch5", sample_ch5, 32'h485);

        // Enable dropped mid-frame: silent abort, then a clean frame.
        for (int k = 0; k < 5; k++) send(3'(k), 32'h4F0 + 32'(k));
        enable = 1'b0; adc_valid = 1'b0;
        #1 check("dis_ready", {31'd0, adc_ready}, 32'd0);
        @(negedge clk);
        check("dis_busy", {31'd0, busy}, 32'd0);
        check("dis_drops", drop_count, 32'd3);
        enable = 1'b1;
        for (int k = 0; k < 8; k++) send(3'(k), 32'h500 + 32'(k));
        check("reen_valid", {31'd0, sample_valid}, 32'd1);
        check("reen_ch3", sample_ch3, 32'h503);
        check("reen_frames", frame_count, 32'd4);

        // Three back-to-back frames: strobes exactly 8 cycles apart, outputs held.
        prev_ch0 = 32'h500;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 8; k++) begin
                send(3'(k), 32'h600 + 32'(16 * f + k));
                check("b2b_valid", {31'd0, sample_valid}, (k == 7) ? 32'd1 : 32'd0);
                check("b2b_hold", sample_ch0, (k == 7) ? 32'h600 + 32'(16 * f) : prev_ch0);
            end
            prev_ch0 = 32'h600 + 32'(16 * f);
        end
        check("b2b_frames", frame_count, 32'd7);
        check("b2b_ts_now", ts_now, cap_ts);
        idle(1);

        // Reset mid-frame.
        for (int k = 0; k < 5; k++) send(3'(k), 32'h700 + 32'(k));
        rst = 1'b1; adc_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_valid", {31'd0, sample_valid}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_frames", frame_count, 32'd0);
        check("mrst_drops", drop_count, 32'd0);
        check("mrst_ts_now", ts_now, 32'd0);
        check("mrst_ch0", sample_ch0, 32'd0);
        check("mrst_ch7", sample_ch7, 32'd0);
        check("mrst_ts_counter", ts_counter, 32'hFFFF_FFFE);
        idle(2);
        check("mrst_nostrobe", {31'd0, sample_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
